// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Bundles every bus signal around the two-requester memory arbiter:
//   icache_*  : instruction fetch requester (read-only, word access)
//   dcache_*  : data requester (read/write, byte/half/word)
//   mem_*     : single downstream memory port
//   bus_err   : timeout abort pulse
// Modports:
//   slave  - the arbiter's view (takes requests, drives grants and mem_*)
//   master - the surrounding system's view (requesters plus memory model)
interface mem_arbiter_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_rdy;
  logic [31:0] icache_data;

  logic        dcache_req;
  logic        dcache_wr;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic [1:0]  dcache_ws;
  logic        dcache_rdy;
  logic [31:0] dcache_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_ws;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  logic        bus_err;

  modport slave (
    input  icache_req, icache_addr,
    output icache_rdy, icache_data,
    input  dcache_req, dcache_wr, dcache_addr, dcache_wdata, dcache_ws,
    output dcache_rdy, dcache_rdata,
    output mem_req, mem_wr, mem_addr, mem_wdata, mem_ws,
    input  mem_rdata, mem_rdy,
    output bus_err
  );

  modport master (
    output icache_req, icache_addr,
    input  icache_rdy, icache_data,
    output dcache_req, dcache_wr, dcache_addr, dcache_wdata, dcache_ws,
    input  dcache_rdy, dcache_rdata,
    input  mem_req, mem_wr, mem_addr, mem_wdata, mem_ws,
    output mem_rdata, mem_rdy,
    input  bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter sharing one memory port between an instruction fetch
// requester and a data requester. Request fields are captured on grant entry
// and held on mem_* for the whole grant; completion is signalled by a
// one-cycle rdy pulse to the granted requester. A grant that sees no mem_rdy
// for TIMEOUT_CYCLES cycles is aborted with bus_err and a zero-data rdy pulse.
// Ports:
//   clock  - sole clock, rising edge
//   reset  - synchronous, active-high
//   bus    - mem_arbiter_if.slave (requester, memory and bus_err signals)
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no grant; mem_req=0; mem_rdy ignored
// GRANT_I | icache owns memory port; waiting mem_rdy/timeout
// GRANT_D | dcache owns memory port; waiting mem_rdy/timeout
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  state_t      last_grant;
  logic [15:0] wait_cnt;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic        cap_wr;
  logic [1:0]  cap_ws;

  logic        granted;
  logic        timeout;
  logic        done;

  // Next-state and combinational outputs
  always_comb begin
    state_nxt        = state;
    granted          = (state == GRANT_I) || (state == GRANT_D);
    // mem_rdy in the terminal cycle wins over the abort
    timeout          = granted && (wait_cnt == WAIT_LAST) && !bus.mem_rdy;
    done             = granted && (bus.mem_rdy || timeout);

    bus.mem_req      = granted;
    bus.mem_wr       = granted ? cap_wr    : 1'b0;
    bus.mem_addr     = granted ? cap_addr  : 32'd0;
    bus.mem_wdata    = granted ? cap_wdata : 32'd0;
    bus.mem_ws       = granted ? cap_ws    : 2'b00;
    bus.bus_err      = timeout;

    bus.icache_rdy   = 1'b0;
    bus.icache_data  = 32'd0;
    bus.dcache_rdy   = 1'b0;
    bus.dcache_rdata = 32'd0;

    case (state)
      IDLE: begin
        if (bus.icache_req && bus.dcache_req)
          state_nxt = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        else if (bus.icache_req)
          state_nxt = GRANT_I;
        else if (bus.dcache_req)
          state_nxt = GRANT_D;
      end
      GRANT_I: begin
        bus.icache_rdy  = done;
        bus.icache_data = bus.mem_rdy ? bus.mem_rdata : 32'd0;
        if (done) state_nxt = IDLE;
      end
      GRANT_D: begin
        bus.dcache_rdy   = done;
        bus.dcache_rdata = bus.mem_rdy ? bus.mem_rdata : 32'd0;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      wait_cnt   <= 16'd0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_wr     <= 1'b0;
      cap_ws     <= 2'b00;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && (state_nxt != IDLE)) begin
        last_grant <= state_nxt;
        wait_cnt   <= 16'd0;
        if (state_nxt == GRANT_I) begin
          // Fetches are always word reads
          cap_addr  <= bus.icache_addr;
          cap_wdata <= 32'd0;
          cap_wr    <= 1'b0;
          cap_ws    <= 2'b10;
        end else begin
          cap_addr  <= bus.dcache_addr;
          cap_wdata <= bus.dcache_wdata;
          cap_wr    <= bus.dcache_wr;
          cap_ws    <= bus.dcache_ws;
        end
      end else if (granted && !bus.mem_rdy) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter built with TIMEOUT_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// following falling edge.
module tb_mem_arbiter;

  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clk_drive();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    reset            = 1'b1;
    bus.icache_req   = 1'b0;
    bus.icache_addr  = 32'd0;
    bus.dcache_req   = 1'b0;
    bus.dcache_wr    = 1'b0;
    bus.dcache_addr  = 32'd0;
    bus.dcache_wdata = 32'd0;
    bus.dcache_ws    = 2'b00;
    bus.mem_rdata    = 32'd0;
    bus.mem_rdy      = 1'b0;

    // Reset state, then single fetch with mem_rdy on the 3rd granted cycle
    clk_drive();
    clk_drive();
    reset           = 1'b0;
    bus.icache_req  = 1'b1;
    bus.icache_addr = 32'h0000_0100;
    sample();
    chk("rst_mem_req",   32'(bus.mem_req),    32'd0);
    chk("rst_mem_wr",    32'(bus.mem_wr),     32'd0);
    chk("rst_mem_ws",    32'(bus.mem_ws),     32'd0);
    chk("rst_mem_addr",  bus.mem_addr,        32'd0);
    chk("rst_mem_wdata", bus.mem_wdata,       32'd0);
    chk("rst_irdy",      32'(bus.icache_rdy), 32'd0);
    chk("rst_drdy",      32'(bus.dcache_rdy), 32'd0);
    chk("rst_bus_err",   32'(bus.bus_err),    32'd0);
    chk("rst_idata",     bus.icache_data,     32'd0);
    chk("rst_ddata",     bus.dcache_rdata,    32'd0);

    clk_drive();
    sample();
    chk("f_mem_req",  32'(bus.mem_req),    32'd1);
    chk("f_mem_addr", bus.mem_addr,        32'h0000_0100);
    chk("f_mem_wr",   32'(bus.mem_wr),     32'd0);
    chk("f_mem_ws",   32'(bus.mem_ws),     32'd2);
    chk("f_irdy_c1",  32'(bus.icache_rdy), 32'd0);
    clk_drive();
    sample();
    chk("f_irdy_c2",  32'(bus.icache_rdy), 32'd0);
    clk_drive();
    bus.mem_rdy    = 1'b1;
    bus.mem_rdata  = 32'hDEAD_BEEF;
    bus.icache_req = 1'b0;
    sample();
    chk("f_irdy",    32'(bus.icache_rdy), 32'd1);
    chk("f_idata",   bus.icache_data,     32'hDEAD_BEEF);
    chk("f_drdy",    32'(bus.dcache_rdy), 32'd0);
    chk("f_ddata",   bus.dcache_rdata,    32'd0);
    chk("f_bus_err", 32'(bus.bus_err),    32'd0);
    clk_drive();
    bus.mem_rdy = 1'b0;
    sample();
    chk("f_idle_req",  32'(bus.mem_req),    32'd0);
    chk("f_idle_irdy", 32'(bus.icache_rdy), 32'd0);
    chk("f_idle_idat", bus.icache_data,     32'd0);

    // Both requests held from reset: grants D, I, D, I with one bubble each
    reset            = 1'b1;
    bus.icache_req   = 1'b1;
    bus.icache_addr  = 32'h0000_0400;
    bus.dcache_req   = 1'b1;
    bus.dcache_wr    = 1'b0;
    bus.dcache_addr  = 32'h0000_3000;
    bus.dcache_ws    = 2'b10;
    clk_drive();
    clk_drive();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      logic is_d;
      is_d = (t % 2 == 0);
      clk_drive();
      bus.mem_rdy   = 1'b1;
      bus.mem_rdata = 32'h0000_00A0 + 32'(t);
      sample();
      chk("rr_mem_addr", bus.mem_addr, is_d ? 32'h0000_3000 : 32'h0000_0400);
      chk("rr_drdy",     32'(bus.dcache_rdy), 32'(is_d));
      chk("rr_irdy",     32'(bus.icache_rdy), 32'(!is_d));
      chk("rr_ddata",    bus.dcache_rdata, is_d ? 32'h0000_00A0 + 32'(t) : 32'd0);
      chk("rr_idata",    bus.icache_data,  is_d ? 32'd0 : 32'h0000_00A0 + 32'(t));
      clk_drive();
      bus.mem_rdy = 1'b0;
      if (t == 3) begin
        bus.icache_req = 1'b0;
        bus.dcache_req = 1'b0;
      end
      sample();
      chk("rr_bubble", 32'(bus.mem_req), 32'd0);
    end

    // dcache half-word write; inputs change and req drops mid-grant
    clk_drive();
    bus.dcache_req   = 1'b1;
    bus.dcache_wr    = 1'b1;
    bus.dcache_addr  = 32'h0000_2000;
    bus.dcache_wdata = 32'h1234_5678;
    bus.dcache_ws    = 2'b01;
    clk_drive();
    bus.dcache_req   = 1'b0;
    bus.dcache_wr    = 1'b0;
    bus.dcache_addr  = 32'hFFFF_0000;
    bus.dcache_wdata = 32'h0BAD_0BAD;
    bus.dcache_ws    = 2'b10;
    sample();
    chk("w_mem_req",   32'(bus.mem_req), 32'd1);
    chk("w_mem_wr",    32'(bus.mem_wr),  32'd1);
    chk("w_mem_ws",    32'(bus.mem_ws),  32'd1);
    chk("w_mem_addr",  bus.mem_addr,     32'h0000_2000);
    chk("w_mem_wdata", bus.mem_wdata,    32'h1234_5678);
    clk_drive();
    sample();
    chk("w_addr_hold",  bus.mem_addr,        32'h0000_2000);
    chk("w_wdata_hold", bus.mem_wdata,       32'h1234_5678);
    chk("w_wr_hold",    32'(bus.mem_wr),     32'd1);
    chk("w_ws_hold",    32'(bus.mem_ws),     32'd1);
    chk("w_drdy_c2",    32'(bus.dcache_rdy), 32'd0);
    clk_drive();
    bus.mem_rdy   = 1'b1;
    bus.mem_rdata = 32'h0000_CAFE;
    sample();
    chk("w_drdy",      32'(bus.dcache_rdy), 32'd1);
    chk("w_ddata",     bus.dcache_rdata,    32'h0000_CAFE);
    chk("w_addr_last", bus.mem_addr,        32'h0000_2000);
    chk("w_bus_err",   32'(bus.bus_err),    32'd0);
    clk_drive();
    bus.mem_rdy = 1'b0;
    sample();
    chk("w_drdy_once", 32'(bus.dcache_rdy), 32'd0);
    chk("w_idle_req",  32'(bus.mem_req),    32'd0);

    // mem_rdy while idle is ignored
    clk_drive();
    bus.mem_rdy   = 1'b1;
    bus.mem_rdata = 32'h0000_0055;
    sample();
    chk("ir_irdy",  32'(bus.icache_rdy), 32'd0);
    chk("ir_drdy",  32'(bus.dcache_rdy), 32'd0);
    chk("ir_idata", bus.icache_data,     32'd0);
    chk("ir_ddata", bus.dcache_rdata,    32'd0);
    chk("ir_err",   32'(bus.bus_err),    32'd0);
    clk_drive();
    bus.mem_rdy = 1'b0;
    sample();
    chk("ir_req", 32'(bus.mem_req), 32'd0);

    // Timeout: icache grant, no mem_rdy, abort on 4th granted cycle
    bus.icache_req  = 1'b1;
    bus.icache_addr = 32'h0000_0500;
    bus.mem_rdata   = 32'h0000_0BAD;
    for (int g = 1; g <= 4; g++) begin
      clk_drive();
      if (g == 4) bus.icache_req = 1'b0;
      sample();
      chk("to_mem_req", 32'(bus.mem_req),    32'd1);
      chk("to_bus_err", 32'(bus.bus_err),    32'(g == 4));
      chk("to_irdy",    32'(bus.icache_rdy), 32'(g == 4));
      chk("to_idata",   bus.icache_data,     32'd0);
    end
    clk_drive();
    sample();
    chk("to_after_req", 32'(bus.mem_req),    32'd0);
    chk("to_after_err", 32'(bus.bus_err),    32'd0);
    chk("to_after_rdy", 32'(bus.icache_rdy), 32'd0);

    // mem_rdy in the timeout cycle completes normally
    bus.dcache_req  = 1'b1;
    bus.dcache_wr   = 1'b0;
    bus.dcache_addr = 32'h0000_0600;
    bus.dcache_ws   = 2'b10;
    for (int g = 1; g <= 4; g++) begin
      clk_drive();
      if (g == 4) begin
        bus.mem_rdy    = 1'b1;
        bus.mem_rdata  = 32'h0000_0077;
        bus.dcache_req = 1'b0;
      end
      sample();
      chk("tr_drdy", 32'(bus.dcache_rdy), 32'(g == 4));
      chk("tr_err",  32'(bus.bus_err),    32'd0);
    end
    chk("tr_ddata", bus.dcache_rdata, 32'h0000_0077);
    clk_drive();
    bus.mem_rdy = 1'b0;
    sample();
    chk("tr_after_req", 32'(bus.mem_req), 32'd0);

    // Reset mid-grant abandons the transaction
    bus.icache_req  = 1'b1;
    bus.icache_addr = 32'h0000_0700;
    clk_drive();
    sample();
    chk("rm_mem_req", 32'(bus.mem_req), 32'd1);
    clk_drive();
    reset = 1'b1;
    sample();
    chk("rm_irdy_pre", 32'(bus.icache_rdy), 32'd0);
    clk_drive();
    reset          = 1'b0;
    bus.icache_req = 1'b0;
    sample();
    chk("rm_req_after",  32'(bus.mem_req),    32'd0);
    chk("rm_irdy_after", 32'(bus.icache_rdy), 32'd0);
    chk("rm_addr_after", bus.mem_addr,        32'd0);
    clk_drive();
    sample();
    chk("rm_req_idle", 32'(bus.mem_req),    32'd0);
    chk("rm_irdy_idle", 32'(bus.icache_rdy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, granted cycles without mem_rdy before the transaction is aborted (range 1..65535).
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 icache_req  input  1  instruction fetch request, held until icache_rdy.
REQ-005 icache_addr  input  32  fetch address.
REQ-006 icache_rdy  output  1  one-cycle completion pulse to the fetch requester.
REQ-007 icache_data  output  32  fetch data, valid only while icache_rdy=1.
REQ-008 dcache_req  input  1  data request, held until dcache_rdy.
REQ-009 dcache_wr  input  1  1=write, 0=read.
REQ-010 dcache_addr  input  32  data address.
REQ-011 dcache_wdata  input  32  write data.
REQ-012 dcache_ws  input  2  access size: 00 byte, 01 half, 10 word.
REQ-013 dcache_rdy  output  1  one-cycle completion pulse to the data requester.
REQ-014 dcache_rdata  output  32  read data, valid only while dcache_rdy=1.
REQ-015 mem_req  output  1  downstream request, held until mem_rdy or timeout.
REQ-016 mem_wr  output  1  downstream write enable.
REQ-017 mem_addr  output  32  downstream address.
REQ-018 mem_wdata  output  32  downstream write data.
REQ-019 mem_ws  output  2  downstream access size.
REQ-020 mem_rdata  input  32  downstream read data, valid with mem_rdy.
REQ-021 mem_rdy  input  1  downstream completion pulse.
REQ-022 bus_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-023 State machine SHALL have states IDLE, GRANT_I, GRANT_D.
REQ-024 In IDLE with exactly one request, the next state SHALL be the matching GRANT state.
REQ-025 In IDLE with both requests, the next state SHALL be the grant for the requester not granted last (round-robin); a last_grant register SHALL update on every grant.
REQ-026 On entry to a GRANT state, the requester's addr, wdata, wr and ws SHALL be registered and driven on mem_* for the whole grant; mem_req SHALL be 1 for the whole grant.
REQ-027 GRANT_I SHALL drive mem_wr=0, mem_ws=2'b10 and mem_wdata=0.
REQ-028 Latency: a request sampled in IDLE at edge N SHALL produce mem_req=1 in the cycle after edge N; there is no combinational path from *_req to mem_req.
REQ-029 In a GRANT state with mem_rdy=1, the granted requester's rdy SHALL be 1 and its data SHALL equal mem_rdata in that same cycle (combinational), and the next state SHALL be IDLE.
REQ-030 The non-granted requester's rdy and data SHALL be 0 at all times; both data outputs SHALL be 0 whenever their rdy is 0.
REQ-031 One IDLE bubble SHALL separate consecutive transactions; minimum transaction spacing is 2 cycles.
REQ-032 mem_rdy in IDLE SHALL be ignored.
REQ-033 A wait counter SHALL clear on grant entry and increment each granted cycle without mem_rdy; when it reaches TIMEOUT_CYCLES-1 without mem_rdy, the arbiter SHALL pulse bus_err and the granted rdy for one cycle with data=0, then return to IDLE.
REQ-034 mem_rdy arriving in the same cycle as the timeout SHALL take precedence: normal completion, bus_err=0.
REQ-035 A requester dropping req mid-grant SHALL NOT abort the transaction; the rdy pulse SHALL still be issued.
REQ-036 Captured request fields SHALL NOT change during a grant regardless of input changes.

Reset
REQ-037 While reset=1 at an edge: state=IDLE, last_grant=GRANT_I (first tie goes to dcache), wait counter=0, captured fields=0.
REQ-038 After reset: mem_req, mem_wr, icache_rdy, dcache_rdy and bus_err SHALL be 0; all 32-bit outputs and mem_ws SHALL be 0.
REQ-039 Reset asserted mid-grant SHALL abandon the transaction with no rdy pulse; mem_req=0 in the cycle after the reset edge.

Verification
REQ-040 icache_req=1, addr=0x100; mem_rdy after 3 cycles with rdata=0xDEADBEEF -> mem_req rises 1 cycle after req; icache_rdy=1 and icache_data=0xDEADBEEF in the mem_rdy cycle; state returns to IDLE.
REQ-041 Both requests held from reset for 4 transactions -> grant order D, I, D, I; each spaced by one IDLE cycle.
REQ-042 dcache write addr=0x2000, wdata=0x12345678, ws=01 -> mem_wr=1 and mem_ws=01, with mem_* fields stable until mem_rdy; dcache_rdy pulses once.
REQ-043 TIMEOUT_CYCLES=4, icache grant with no mem_rdy -> bus_err and icache_rdy pulse on the 4th granted cycle with data=0, then mem_req=0.
REQ-044 mem_rdy in the timeout cycle -> normal completion with bus_err=0; reset mid-grant -> no rdy pulse and mem_req=0 in the next cycle.
REQ-045 mem_rdy pulsed in IDLE and dcache_addr changed mid-grant -> no rdy pulse from the idle mem_rdy; mem_addr keeps the captured value.
